// File: rtl/dec_scan_pkg.sv
// Shared encodings for the dec_24 scan sequencer.
// State values are fixed so that status decoding stays stable across revisions.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

endpackage

// File: rtl/dec_scan_ctrl_dwell_ctr.sv
// Loadable down-counter that times how long each decoder line is held.
// load wins over dec; zero reflects the registered count.
module dwell_ctr #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Sequencer driving dec_24 select/enable so d0..d3 assert one at a time,
// each for a latched dwell, in single-sweep or continuous mode.
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a1,
  output logic               a0,
  output logic               en,
  output logic               busy,
  output logic               done
);

  // Handshake: start is accepted only in IDLE (and beats a same-cycle stop),
  // stop is honoured only in SCAN, busy is high for the whole SCAN, and done
  // pulses for one cycle after a single sweep ends without being stopped.

  state_t             state, state_n;
  logic [IDX_W-1:0]   index, index_n;
  logic               cont_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] dwell_in;
  logic [DWELL_W-1:0] ctr_val;
  logic               ctr_load, ctr_dec, ctr_zero;
  logic               latch;

  assign dwell_in = (dwell == '0) ? DWELL_W'(1) : dwell;

  dwell_ctr #(.DWELL_W(DWELL_W)) u_dwell_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_comb begin
    state_n  = state;
    index_n  = index;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ctr_val  = dwell_l - 1'b1;
    latch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_SCAN;
          index_n  = '0;
          ctr_load = 1'b1;
          ctr_val  = dwell_in - 1'b1;
          latch    = 1'b1;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (!ctr_zero) begin
          ctr_dec = 1'b1;
        end else if (index != LAST_IDX) begin
          index_n  = index + 1'b1;
          ctr_load = 1'b1;
        end else if (cont_l) begin
          index_n  = '0;
          ctr_load = 1'b1;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      index   <= '0;
      cont_l  <= 1'b0;
      dwell_l <= DWELL_W'(1);
    end else begin
      state <= state_n;
      index <= index_n;
      if (latch) begin
        cont_l  <= cont;
        dwell_l <= dwell_in;
      end
    end
  end

  // Outputs are loaded from next-state values so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1   <= 1'b0;
      a0   <= 1'b0;
      en   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      {a1, a0} <= (state_n == ST_SCAN) ? index_n : '0;
      en       <= (state_n == ST_SCAN);
      busy     <= (state_n == ST_SCAN);
      done     <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: driver pushes hand-computed expected output words,
// a negedge monitor pops one whenever en or done is high.
module tb_dec_scan_ctrl;

  localparam int DWELL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               start, stop, cont;
  logic [DWELL_W-1:0] dwell;
  logic               a1, a0, en, busy, done;
  logic [3:0]         d;

  logic [8:0] exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;

  dec_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .dwell (dwell),
    .a1    (a1),
    .a0    (a0),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  // dec_24 model fed by the sequencer
  assign d = en ? (4'b0001 << {a1, a0}) : 4'b0000;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] w(input bit dn, input bit e, input bit b, input logic [1:0] s);
    logic [3:0] dl;
    dl = e ? (4'b0001 << s) : 4'b0000;
    return {dn, e, b, s, dl};
  endfunction

  function automatic logic [8:0] act_word();
    return {done, en, busy, a1, a0, d};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (en || done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %b expected none at %0t", act_word(), $time);
      end else begin
        check("scan_word", act_word(), exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [DWELL_W-1:0] dw, input logic c);
    dwell = dw;
    cont  = c;
    start = 1'b1;
    cyc();
    start = 1'b0;
    dwell = DWELL_W'($urandom_range(0, 15));
    cont  = 1'($urandom_range(0, 1));
  endtask

  task automatic push_sweep(input int dl, input bit with_done);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < dl; k++) exp_q.push_back(w(0, 1, 1, 2'(i)));
    if (with_done) exp_q.push_back(w(1, 0, 0, 2'd0));
  endtask

  task automatic check_quiet(input string name);
    check(name, 9'(exp_q.size()), 9'd0);
    check(name, act_word(), w(0, 0, 0, 2'd0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    stop  = 1'($urandom_range(0, 1));
    cont  = 1'($urandom_range(0, 1));
    dwell = DWELL_W'($urandom_range(0, 15));
    #2;
    check("reset_async", act_word(), w(0, 0, 0, 2'd0));
    cyc(3);
    check("reset_hold", act_word(), w(0, 0, 0, 2'd0));
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cyc(3);
    check_quiet("idle_after_reset");

    // single sweep, dwell=2
    push_sweep(2, 1);
    do_start(4'd2, 1'b0);
    cyc(12);
    check_quiet("single_dwell2");

    // dwell=0 behaves as dwell=1; stop in IDLE is ignored
    stop = 1'b1;
    cyc(2);
    stop = 1'b0;
    check_quiet("stop_in_idle");
    push_sweep(1, 1);
    do_start(4'd0, 1'b0);
    cyc(8);
    check_quiet("single_dwell0");

    // continuous dwell=1, stop while index=2
    for (int i = 0; i < 7; i++) exp_q.push_back(w(0, 1, 1, 2'(i % 4)));
    do_start(4'd1, 1'b1);
    cyc(6);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("after_stop", act_word(), w(0, 0, 0, 2'd0));
    cyc(4);
    check_quiet("cont_stop");

    // dwell=3, restart attempt mid-scan, stop on final expiry edge
    push_sweep(3, 0);
    do_start(4'd3, 1'b0);
    cyc(3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(7);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc(4);
    check_quiet("stop_expiry_collision");

    // mid-sweep reset at index 1
    exp_q.push_back(w(0, 1, 1, 2'd0));
    exp_q.push_back(w(0, 1, 1, 2'd0));
    exp_q.push_back(w(0, 1, 1, 2'd1));
    do_start(4'd2, 1'b0);
    cyc(2);
    #5;
    rst_n = 1'b0;
    #1;
    check("midsweep_reset_async", act_word(), w(0, 0, 0, 2'd0));
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check_quiet("after_midsweep_reset");
    push_sweep(1, 1);
    do_start(4'd1, 1'b0);
    cyc(8);
    check_quiet("restart_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dec_scan_ctrl.md
Name: dec_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 2-to-4 line decoder (dec_24).
- Drives the decoder's select pair (a1,a0) and enable (in) so that output lines d0..d3 are asserted one at a time, in order.
- Each line is held for a programmable number of cycles (the dwell).
- Supports single-sweep and continuous modes, a start/stop handshake, and busy/done status for the controlling logic.

Parameters:
- DWELL_W, 4, width of the dwell count input; dwell range 1..2^DWELL_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- stop  input  1  abort the sweep; sampled only in SCAN.
- cont  input  1  1 = wrap continuously, 0 = single sweep; latched at start.
- dwell  input  DWELL_W  cycles per line; latched at start; 0 is treated as 1.
- a1  output  1  decoder select MSB.
- a0  output  1  decoder select LSB.
- en  output  1  decoder enable (drives dec_24 input "in").
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a single sweep completes.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n; all flops clear immediately when rst_n=0.
- All outputs are registered. Reset values: a1=0, a0=0, en=0, busy=0, done=0. Reset state is IDLE; internal index=0 and count=0.
- States:
  - IDLE: en=0, busy=0, {a1,a0}=00.
  - SCAN: en=1, busy=1, {a1,a0}=index.
  - DONE: en=0, busy=0, done=1, {a1,a0}=00.
- Encoding lives in the package.
- IDLE -> SCAN: at the edge where start=1. On that edge:
  - latch cont;
  - latch dwell_l = (dwell==0) ? 1 : dwell;
  - index=0, count=dwell_l-1;
  - en, busy and a1/a0 take SCAN values on the same edge, i.e. latency 1 cycle from start sampled to en high.
- SCAN, on each edge, in this priority:
  1. stop=1: go to IDLE with en=0 next cycle, no done pulse. stop wins over dwell expiry on the same edge.
  2. count!=0: count decrements.
  3. count==0 and index!=3: index increments, count reloads to dwell_l-1.
  4. count==0 and index==3 and cont=1: index wraps to 0, count reloads; en stays high with no gap.
  5. count==0 and index==3 and cont=0: go to DONE.
- DONE -> IDLE unconditionally after one cycle.
- Select changes and en are continuous across index changes. There are no bubble cycles, so exactly one decoder line is high per SCAN cycle.
- Single-sweep en-high duration is exactly 4*dwell_l cycles.
- start in SCAN or DONE is ignored. stop in IDLE or DONE is ignored. start and stop asserted together in IDLE: start wins.
- dwell and cont changes during SCAN have no effect until the next start.
- rst_n asserted mid-sweep: outputs drop to reset values asynchronously. After release the block stays in IDLE until a new start; no done pulse is produced.

Decomposition:
- Shared package dec_scan_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2;
  - IDX_W=2;
  - LAST_IDX=2'd3.
- One natural sub-module: dwell_ctr, a loadable DWELL_W-bit down-counter with load, dec and zero flag, clk/rst_n.
- The FSM, index register and output registers stay in dec_scan_ctrl.

Test Plan:
- Reset: rst_n=0 with random inputs -> a1=a0=en=busy=done=0 immediately; start held while rst_n=0 is ignored.
- Single sweep, dwell=2, cont=0, start pulsed 1 cycle:
  - en high for 8 cycles with {a1,a0} = 00,00,01,01,10,10,11,11;
  - done=1 on cycle 9, then IDLE;
  - when en drives dec_24 (in), d0..d3 each go high for 2 cycles in order.
- dwell=0, cont=0 -> behaves as dwell=1: {a1,a0} = 00,01,10,11, one cycle each, then done pulse.
- Continuous, dwell=1, cont=1 -> index sequence 0,1,2,3,0,1... with en never dropping. stop asserted while index=2 -> en=0 and busy=0 next cycle; done never pulses.
- Stop/expiry collision: dwell=3, cont=0, stop asserted on the final count==0 edge at index 3 -> IDLE entered, no done pulse. A second start during SCAN does not restart the index.
- Mid-sweep reset: rst_n pulled low at index=1 -> outputs clear asynchronously. After release with no start, en stays 0; a new start begins at index 0.
